// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter muxing the granted master onto one slave-side bus.
// Optional stalled-strobe bus timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_gnt_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_gnt_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic              wb_ack_i,
  input  logic [DATA_W-1:0] wb_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   gnt0, gnt1;
  logic   timeout_c;

  assign gnt0 = (state_q == ST_GNT0);
  assign gnt1 = (state_q == ST_GNT1);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_c;

  // A stalled cycle is a granted strobe the slave has not acked yet.
  assign stall_c   = ((gnt0 && m0_stb_i) || (gnt1 && m1_stb_i)) && !wb_ack_i;
  assign timeout_c = stall_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || wb_ack_i || timeout_c) begin
      cnt_d = '0;
    end else if (stall_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_c;

  assign timeout_c        = 1'b0;
  assign unused_timeout_c = (TIMEOUT_CYCLES == 0);
`endif

  // Grant FSM: a grant is held until its master drops cyc; ties go to the master not served last.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_gnt_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (timeout_c) begin
          state_d    = ST_IDLE;
          last_gnt_d = 1'b0;
        end else if (!m0_cyc_i) begin
          state_d    = m1_cyc_i ? ST_GNT1 : ST_IDLE;
          last_gnt_d = 1'b0;
        end
      end
      ST_GNT1: begin
        if (timeout_c) begin
          state_d    = ST_IDLE;
          last_gnt_d = 1'b1;
        end else if (!m1_cyc_i) begin
          state_d    = m0_cyc_i ? ST_GNT0 : ST_IDLE;
          last_gnt_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Slave-side mux follows the registered grant so reset releases the bus at once.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = '0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    if (gnt0) begin
      wb_cyc_o = m0_cyc_i;
      wb_stb_o = m0_stb_i;
      wb_we_o  = m0_we_i;
      wb_sel_o = m0_sel_i;
      wb_adr_o = m0_adr_i;
      wb_dat_o = m0_dat_i;
    end else if (gnt1) begin
      wb_cyc_o = m1_cyc_i;
      wb_stb_o = m1_stb_i;
      wb_we_o  = m1_we_i;
      wb_sel_o = m1_sel_i;
      wb_adr_o = m1_adr_i;
      wb_dat_o = m1_dat_i;
    end
    if (timeout_c) begin
      wb_cyc_o = 1'b0;
      wb_stb_o = 1'b0;
    end
  end

  assign m0_ack_o = wb_ack_i && gnt0;
  assign m1_ack_o = wb_ack_i && gnt1;
  assign m0_dat_o = gnt0 ? wb_dat_i : '0;
  assign m1_dat_o = gnt1 ? wb_dat_i : '0;
  assign m0_err_o = timeout_c && gnt0;
  assign m1_err_o = timeout_c && gnt1;
  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

endmodule
